// File: rtl/msx_cas_tx_pkg.sv
// Shared cassette definitions: frame FSM state encodings, framing constants and the FSK level map.
// The cassette input path imports the same package, so both directions agree on bit encoding.
package msx_cas_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } cas_state_e;

  localparam logic START_BIT_VAL = 1'b0;
  localparam int   DATA_BITS     = 8;
  localparam int   STOP_BITS     = 2;
  localparam int   QTRS_PER_BIT  = 4;

  // '1' toggles every quarter (2400 Hz); '0' toggles every two quarters (1200 Hz).
  function automatic logic cas_level(input logic bit_val, input logic [1:0] qtr);
    return bit_val ? ~qtr[0] : ~qtr[1];
  endfunction

endpackage

// File: rtl/cas_bit_gen.sv
// One FSK bit: quarter prescaler plus 2-bit quarter index; level is registered, high from the cycle after start.
// bit_done flags the last clock of the bit so the caller can chain the next start with no gap.
module cas_bit_gen
  import msx_cas_tx_pkg::*;
#(
  parameter int QUARTER_DIV = 746
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_val,
  output logic level,
  output logic bit_done
);

  localparam int PW = (QUARTER_DIV > 1) ? $clog2(QUARTER_DIV) : 1;

  logic          active;
  logic          cur_bit;
  logic [PW-1:0] pre_cnt;
  logic [1:0]    qtr;
  logic          qtr_end;

  assign qtr_end  = active && (pre_cnt == PW'(QUARTER_DIV - 1));
  assign bit_done = qtr_end && (qtr == 2'(QTRS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      cur_bit <= 1'b0;
      pre_cnt <= '0;
      qtr     <= '0;
      level   <= 1'b0;
    end else if (start) begin
      // Both encodings open with a high quarter.
      active  <= 1'b1;
      cur_bit <= bit_val;
      pre_cnt <= '0;
      qtr     <= '0;
      level   <= 1'b1;
    end else if (qtr_end) begin
      pre_cnt <= '0;
      qtr     <= qtr + 2'd1;
      if (bit_done) begin
        active <= 1'b0;
        level  <= 1'b0;
      end else begin
        level  <= cas_level(cur_bit, qtr + 2'd1);
      end
    end else if (active) begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/msx_cas_tx.sv
// MSX cassette FSK transmitter: headers and 11-bit byte frames onto cas_out, first edge one clock after accept.
// Requests are taken only while ready (idle); optional sent_count under CAS_TX_BYTE_COUNT_EN.
module msx_cas_tx
  import msx_cas_tx_pkg::*;
#(
  parameter int QUARTER_DIV    = 746,
  parameter int LONG_HDR_BITS  = 8000,
  parameter int SHORT_HDR_BITS = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hdr_valid,
  input  logic        hdr_long,
  input  logic        data_valid,
  input  logic [7:0]  data,
  output logic        ready,
  output logic        busy,
  output logic        cas_out
`ifdef CAS_TX_BYTE_COUNT_EN
  ,
  output logic [15:0] sent_count
`endif
);

  cas_state_e  state, state_nxt;
  logic [7:0]  shreg;
  logic [2:0]  cnt;
  logic [13:0] hdr_cnt;
  logic        bit_start;
  logic        bit_val;
  logic        bit_done;

  assign ready = (state == ST_IDLE);
  assign busy  = ~ready;

  cas_bit_gen #(.QUARTER_DIV(QUARTER_DIV)) u_bit_gen (
    .clk      (clk),
    .rst      (rst),
    .start    (bit_start),
    .bit_val  (bit_val),
    .level    (cas_out),
    .bit_done (bit_done)
  );

  always_comb begin
    state_nxt = state;
    bit_start = 1'b0;
    bit_val   = 1'b1;
    case (state)
      ST_IDLE: begin
        if (hdr_valid) begin
          state_nxt = ST_HDR;
          bit_start = 1'b1;
        end else if (data_valid) begin
          state_nxt = ST_START;
          bit_start = 1'b1;
          bit_val   = START_BIT_VAL;
        end
      end
      ST_HDR: begin
        if (bit_done) begin
          if (hdr_cnt == '0) state_nxt = ST_IDLE;
          else               bit_start = 1'b1;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_nxt = ST_DATA;
          bit_start = 1'b1;
          bit_val   = shreg[0];
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          bit_start = 1'b1;
          if (cnt == 3'(DATA_BITS - 1)) state_nxt = ST_STOP;
          else                          bit_val   = shreg[0];
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (cnt == 3'(STOP_BITS - 1)) state_nxt = ST_IDLE;
          else                          bit_start = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      cnt     <= '0;
      hdr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE) begin
        if (hdr_valid) begin
          hdr_cnt <= hdr_long ? 14'(LONG_HDR_BITS - 1) : 14'(SHORT_HDR_BITS - 1);
        end else if (data_valid) begin
          shreg <= data;
          cnt   <= '0;
        end
      end else if (bit_done) begin
        case (state)
          ST_HDR:   if (hdr_cnt != '0) hdr_cnt <= hdr_cnt - 14'd1;
          ST_START: shreg <= shreg >> 1;
          ST_DATA: begin
            // The bit just launched was shreg[0]; shift so the next one is ready.
            shreg <= shreg >> 1;
            cnt   <= (cnt == 3'(DATA_BITS - 1)) ? 3'd0 : cnt + 3'd1;
          end
          ST_STOP:  cnt <= cnt + 3'd1;
          default:  cnt <= cnt;
        endcase
      end
    end
  end

`ifdef CAS_TX_BYTE_COUNT_EN
  logic frame_done;
  assign frame_done = (state == ST_STOP) && bit_done && (cnt == 3'(STOP_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst)             sent_count <= '0;
    else if (frame_done) sent_count <= sent_count + 16'd1;
  end
`endif

endmodule
